render_read_master: RTL and testbench

RENDER_READ_MASTER -- requirements
Module: render_read_master

---
 rtl/render_rm_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/render_read_master.sv | 168 ++++++++++++++++
 tb/tb_render_read_master.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_rm_pkg.sv
// ---------------------------------------------------------------------------
// render_rm_pkg : shared types, default parameters and burst helper for the
// render read master.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package render_rm_pkg;

   localparam int RRM_NCH       = 4;
   localparam int RRM_DW        = 32;
   localparam int RRM_MAX_BURST = 8;
   localparam int RRM_LENW      = 16;

   typedef enum logic [1:0] {
      M_IDLE  = 2'd0,
      M_ISSUE = 2'd1,
      M_DATA  = 2'd2
   } mstate_t;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_BUSY = 1'b1
   } chstate_t;

   // Words in the next burst: limited by what is left and by the distance to
   // the next maxb-word aligned boundary (which is itself at most maxb).
   function automatic logic [31:0] burst_words(input logic [31:0] addr,
                                               input logic [31:0] rem,
                                               input logic [31:0] maxb);
      logic [31:0] to_bnd;
      to_bnd = maxb - ((addr >> 2) & (maxb - 32'd1));
      return (rem < to_bnd) ? rem : to_bnd;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin arbiter with an urgent tier sharing one pointer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
   parameter int NCH = 4,
   parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0] req_i,
   input  logic [NCH-1:0] urgent_i,
   input  logic [IW-1:0]  ptr_i,
   output logic [NCH-1:0] gnt_o,
   output logic [IW-1:0]  gnt_idx_o
);

   logic [NCH-1:0] w_hi;
   logic [NCH-1:0] w_pool;
   logic           w_found;
   int             w_idx;

   always_comb begin
      w_hi      = req_i & urgent_i;
      w_pool    = (|w_hi) ? w_hi : req_i;
      w_found   = 1'b0;
      w_idx     = 0;
      gnt_idx_o = '0;
      for (int k = 0; k < NCH; k++) begin
         w_idx = (int'(ptr_i) + k) % NCH;
         if (!w_found && w_pool[w_idx]) begin
            w_found   = 1'b1;
            gnt_idx_o = IW'(w_idx);
         end
      end
      gnt_o = w_found ? (NCH'(1) << gnt_idx_o) : '0;
   end

endmodule

`default_nettype wire

// File: rtl/render_read_master.sv
// ---------------------------------------------------------------------------
// render_read_master : NCH-channel Avalon-MM burst read master with
// round-robin arbitration. Option: RRM_URGENT_EN (urgent tier).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module render_read_master
   import render_rm_pkg::*;
#(
   parameter int NCH       = RRM_NCH,
   parameter int DW        = RRM_DW,
   parameter int MAX_BURST = RRM_MAX_BURST,
   parameter int LENW      = RRM_LENW,
   parameter int BCW       = $clog2(MAX_BURST) + 1
) (
   input  logic              iClk,
   input  logic              iRstn,
   input  logic [NCH-1:0]    iCmd_valid,
   output logic [NCH-1:0]    oCmd_ready,
   input  logic [NCH*32-1:0] iCmd_addr,
   input  logic [NCH*LENW-1:0] iCmd_len,
   input  logic [NCH-1:0]    iCh_afull,
`ifdef RRM_URGENT_EN
   input  logic [NCH-1:0]    iUrgent,
`endif
   output logic [NCH-1:0]    oCh_valid,
   output logic [DW-1:0]     oCh_data,
   output logic [NCH-1:0]    oCh_done,
   output logic              oRM_read,
   output logic [31:0]       oRM_address,
   output logic [BCW-1:0]    oRM_burstcount,
   input  logic              iRM_waitrequest,
   input  logic              iRM_readdatavalid,
   input  logic [DW-1:0]     iRM_readdata
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   mstate_t         mst_q, mst_d;
   chstate_t        ch_st_q   [NCH];
   logic [31:0]     ch_addr_q [NCH];
   logic [LENW-1:0] ch_rem_q  [NCH];
   logic [NCH-1:0]  done_q;
   logic [IW-1:0]   gnt_q;
   logic [IW-1:0]   rr_ptr_q;
   logic [31:0]     rd_addr_q;
   logic [BCW-1:0]  rd_bc_q;
   logic [BCW-1:0]  beat_q;

   logic [NCH-1:0]  w_elig;
   logic [NCH-1:0]  w_urg;
   logic [NCH-1:0]  w_arb_gnt;
   logic [IW-1:0]   w_arb_idx;
   logic            w_any;
   logic            w_beat;
   logic            w_last;
   logic [31:0]     w_sel_addr;
   logic [LENW-1:0] w_sel_rem;
   logic [31:0]     w_burst;

`ifdef RRM_URGENT_EN
   assign w_urg = iUrgent;
`else
   assign w_urg = '0;
`endif

   // The channel under service is excluded until its burst has retired.
   for (genvar g = 0; g < NCH; g++) begin : g_elig
      assign w_elig[g] = (ch_st_q[g] == CH_BUSY) && (ch_rem_q[g] != '0) &&
                         !iCh_afull[g] &&
                         !((mst_q != M_IDLE) && (gnt_q == IW'(g)));
   end

   rr_arbiter #(
      .NCH (NCH),
      .IW  (IW)
   ) u_arb (
      .req_i     (w_elig),
      .urgent_i  (w_urg),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (w_arb_gnt),
      .gnt_idx_o (w_arb_idx)
   );

   assign w_any      = |w_arb_gnt;
   assign w_sel_addr = ch_addr_q[w_arb_idx];
   assign w_sel_rem  = ch_rem_q[w_arb_idx];
   assign w_burst    = burst_words(w_sel_addr, 32'(w_sel_rem), 32'(MAX_BURST));

   assign w_beat = (mst_q == M_DATA) && iRM_readdatavalid;
   assign w_last = w_beat && (beat_q == (rd_bc_q - 1'b1));

   always_comb begin
      mst_d = mst_q;
      case (mst_q)
         M_IDLE:  if (w_any)            mst_d = M_ISSUE;
         M_ISSUE: if (!iRM_waitrequest) mst_d = M_DATA;
         M_DATA:  if (w_last)           mst_d = M_IDLE;
         default:                       mst_d = M_IDLE;
      endcase
   end

   always_comb begin
      oCh_valid = '0;
      if (w_beat) oCh_valid[gnt_q] = 1'b1;
      oCh_data       = w_beat ? iRM_readdata : '0;
      oRM_read       = (mst_q == M_ISSUE);
      oRM_address    = rd_addr_q;
      oRM_burstcount = rd_bc_q;
      oCh_done       = done_q;
      for (int i = 0; i < NCH; i++) oCmd_ready[i] = (ch_st_q[i] == CH_IDLE);
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         mst_q     <= M_IDLE;
         gnt_q     <= '0;
         rr_ptr_q  <= '0;
         rd_addr_q <= '0;
         rd_bc_q   <= '0;
         beat_q    <= '0;
      end else begin
         mst_q <= mst_d;
         if ((mst_q == M_IDLE) && w_any) begin
            gnt_q     <= w_arb_idx;
            rr_ptr_q  <= (w_arb_idx == IW'(NCH - 1)) ? '0 : w_arb_idx + 1'b1;
            rd_addr_q <= w_sel_addr;
            rd_bc_q   <= BCW'(w_burst);
            beat_q    <= '0;
         end else if (w_beat) begin
            beat_q <= beat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         for (int i = 0; i < NCH; i++) begin
            ch_st_q[i]   <= CH_IDLE;
            ch_addr_q[i] <= '0;
            ch_rem_q[i]  <= '0;
         end
         done_q <= '0;
      end else begin
         done_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            if (ch_st_q[i] == CH_IDLE) begin
               if (iCmd_valid[i]) begin
                  ch_addr_q[i] <= iCmd_addr[i*32 +: 32];
                  ch_rem_q[i]  <= iCmd_len[i*LENW +: LENW];
                  if (iCmd_len[i*LENW +: LENW] == '0) done_q[i] <= 1'b1;
                  else                                ch_st_q[i] <= CH_BUSY;
               end
            end else if (w_last && (gnt_q == IW'(i))) begin
               ch_addr_q[i] <= ch_addr_q[i] + (32'(rd_bc_q) << 2);
               ch_rem_q[i]  <= ch_rem_q[i] - LENW'(rd_bc_q);
               if (ch_rem_q[i] == LENW'(rd_bc_q)) begin
                  ch_st_q[i] <= CH_IDLE;
                  done_q[i]  <= 1'b1;
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_render_read_master.sv
// ---------------------------------------------------------------------------
// tb_render_read_master : directed bench with an Avalon slave model and a
// per-channel sequential-data scoreboard.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_render_read_master;

   localparam int NCH = 4, DW = 32, MAX_BURST = 8, LENW = 16, BCW = 4;

   logic              iClk = 1'b0;
   logic              iRstn = 1'b0;
   logic [NCH-1:0]    iCmd_valid = '0;
   logic [NCH-1:0]    oCmd_ready;
   logic [NCH*32-1:0] iCmd_addr = '0;
   logic [NCH*LENW-1:0] iCmd_len = '0;
   logic [NCH-1:0]    iCh_afull = '0;
`ifdef RRM_URGENT_EN
   logic [NCH-1:0]    iUrgent = '0;
`endif
   logic [NCH-1:0]    oCh_valid;
   logic [DW-1:0]     oCh_data;
   logic [NCH-1:0]    oCh_done;
   logic              oRM_read;
   logic [31:0]       oRM_address;
   logic [BCW-1:0]    oRM_burstcount;
   logic              iRM_waitrequest = 1'b0;
   logic              iRM_readdatavalid = 1'b0;
   logic [DW-1:0]     iRM_readdata = '0;

   render_read_master #(
      .NCH(NCH), .DW(DW), .MAX_BURST(MAX_BURST), .LENW(LENW), .BCW(BCW)
   ) dut (
      .iClk(iClk), .iRstn(iRstn),
      .iCmd_valid(iCmd_valid), .oCmd_ready(oCmd_ready),
      .iCmd_addr(iCmd_addr), .iCmd_len(iCmd_len), .iCh_afull(iCh_afull),
`ifdef RRM_URGENT_EN
      .iUrgent(iUrgent),
`endif
      .oCh_valid(oCh_valid), .oCh_data(oCh_data), .oCh_done(oCh_done),
      .oRM_read(oRM_read), .oRM_address(oRM_address),
      .oRM_burstcount(oRM_burstcount), .iRM_waitrequest(iRM_waitrequest),
      .iRM_readdatavalid(iRM_readdatavalid), .iRM_readdata(iRM_readdata)
   );

   always #5 iClk = ~iClk;

   int cyc = 0;
   always @(posedge iClk) cyc <= cyc + 1;

   int n_cmp = 0, n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pat(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   logic [31:0] iss_addr[$];
   int          iss_bc[$];
   int          gq[$];
   int          vcnt[NCH], dcnt[NCH], done_cyc[NCH];
   logic [31:0] exp_addr[NCH];
   int          rd_seen = 0, first_rd_cyc = 0, acc_cyc = 0;
   bit          rd_arm = 0, new_burst = 0, spur = 0;
   int          pend = 0, wcnt = 0, gap = 0;
   logic [31:0] s_addr = '0;

   // Slave drives at the falling edge; the monitor samples 1 ns later.
   initial forever begin
      @(negedge iClk);
      iRM_readdatavalid = 1'b0;
      iRM_readdata      = '0;
      if (pend > 0) begin
         iRM_waitrequest = 1'b1;
         if ((gap % 4) != 3) begin
            iRM_readdatavalid = 1'b1;
            iRM_readdata      = pat(s_addr);
            s_addr += 4;
            pend--;
         end
         gap++;
      end else if (oRM_read) begin
         if (wcnt == 0) begin
            iRM_waitrequest = 1'b1;
            wcnt = 1;
         end else begin
            iRM_waitrequest = 1'b0;
            wcnt = 0;
            iss_addr.push_back(oRM_address);
            iss_bc.push_back(int'(oRM_burstcount));
            pend = int'(oRM_burstcount);
            s_addr = oRM_address;
            gap = 0;
            new_burst = 1;
         end
      end else begin
         iRM_waitrequest = 1'b0;
         wcnt = 0;
         if (spur) begin
            iRM_readdatavalid = 1'b1;
            iRM_readdata      = 32'hDEAD_BEEF;
         end
      end
      #1;
      if (oRM_read) begin
         rd_seen++;
         if (rd_arm) begin first_rd_cyc = cyc; rd_arm = 0; end
      end
      if (oCh_valid != '0) begin
         int ch = 0;
         for (int c = 0; c < NCH; c++) if (oCh_valid[c]) ch = c;
         check_val("valid_onehot", $countones(oCh_valid), 1);
         check_val($sformatf("data_ch%0d", ch), oCh_data, pat(exp_addr[ch]));
         exp_addr[ch] += 4;
         vcnt[ch]++;
         if (new_burst) begin gq.push_back(ch); new_burst = 0; end
      end
      for (int c = 0; c < NCH; c++)
         if (oCh_done[c]) begin dcnt[c]++; done_cyc[c] = cyc; end
   end

   task automatic clear_logs();
      iss_addr.delete(); iss_bc.delete(); gq.delete();
      for (int c = 0; c < NCH; c++) begin vcnt[c] = 0; dcnt[c] = 0; end
      rd_seen = 0;
   endtask

   task automatic set_cmd(input int ch, input logic [31:0] a, input logic [LENW-1:0] len);
      iCmd_addr[ch*32 +: 32]  = a;
      iCmd_len[ch*LENW +: LENW] = len;
      exp_addr[ch] = a;
   endtask

   task automatic fire(input logic [NCH-1:0] mask);
      @(negedge iClk);
      iCmd_valid = mask;
      acc_cyc = cyc;
      rd_arm = 1;
      @(posedge iClk);
      #1 iCmd_valid = '0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge iClk);
      #2;
   endtask

   task automatic wait_done(input int ch, input int budget);
      int k = 0;
      while (dcnt[ch] < 1 && k < budget) begin @(negedge iClk); #2; k++; end
      check_val($sformatf("done_ch%0d", ch), dcnt[ch], 1);
   endtask

   task automatic wait_beat(input int ch, input int budget);
      int k = 0;
      while (vcnt[ch] < 1 && k < budget) begin @(negedge iClk); #2; k++; end
      check_val($sformatf("first_beat_ch%0d", ch), (vcnt[ch] >= 1), 1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, "_read"},  oRM_read, 0);
      check_val({pfx, "_valid"}, oCh_valid, 0);
      check_val({pfx, "_data"},  oCh_data, 0);
      check_val({pfx, "_done"},  oCh_done, 0);
      check_val({pfx, "_addr"},  oRM_address, 0);
      check_val({pfx, "_bc"},    oRM_burstcount, 0);
      check_val({pfx, "_ready"}, oCmd_ready, 4'hF);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_g[8];
      exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
      for (int c = 0; c < NCH; c++) begin exp_addr[c] = '0; vcnt[c] = 0; dcnt[c] = 0; end

      // Reset with a spurious readdatavalid present: everything stays quiet.
      spur = 1;
      wait_cycles(3);
      check_reset_outputs("rst0");
      @(negedge iClk) iRstn = 1'b1;
      wait_cycles(2);
      check_val("spur_ignored", vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3], 0);
      spur = 0;

      // Fairness right after reset, pointer starts at 0.
      clear_logs();
      set_cmd(0, 32'h2000, 16); set_cmd(1, 32'h3000, 16);
      set_cmd(2, 32'h4000, 16); set_cmd(3, 32'h5000, 16);
      fire(4'hF);
      for (int c = 0; c < NCH; c++) wait_done(c, 600);
      check_val("fair_ngrants", gq.size(), 8);
      for (int k = 0; k < 8; k++)
         if (k < gq.size()) check_val($sformatf("fair_g%0d", k), gq[k], exp_g[k]);
      for (int c = 0; c < NCH; c++) check_val($sformatf("fair_beats_ch%0d", c), vcnt[c], 16);

      // Single command, latency and burst split.
      clear_logs();
      set_cmd(0, 32'h1000, 20);
      fire(4'h1);
      wait_done(0, 400);
      check_val("lat_read", first_rd_cyc - acc_cyc, 2);
      check_val("s1_nburst", iss_addr.size(), 3);
      if (iss_addr.size() == 3) begin
         check_val("s1_a0", iss_addr[0], 32'h1000); check_val("s1_b0", iss_bc[0], 8);
         check_val("s1_a1", iss_addr[1], 32'h1020); check_val("s1_b1", iss_bc[1], 8);
         check_val("s1_a2", iss_addr[2], 32'h1040); check_val("s1_b2", iss_bc[2], 4);
      end
      check_val("s1_beats", vcnt[0], 20);
      wait_cycles(3);
      check_val("s1_ndone", dcnt[0], 1);

      // Boundary shortening.
      clear_logs();
      set_cmd(1, 32'h1018, 8);
      fire(4'h2);
      wait_done(1, 400);
      check_val("bnd_nburst", iss_addr.size(), 2);
      if (iss_addr.size() == 2) begin
         check_val("bnd_a0", iss_addr[0], 32'h1018); check_val("bnd_b0", iss_bc[0], 2);
         check_val("bnd_a1", iss_addr[1], 32'h1020); check_val("bnd_b1", iss_bc[1], 6);
      end
      check_val("bnd_beats", vcnt[1], 8);

      // Back-pressure on ch2; afull raised again mid-burst must not cut it.
      clear_logs();
      iCh_afull[2] = 1'b1;
      set_cmd(2, 32'h6004, 24); set_cmd(0, 32'h7000, 8); set_cmd(3, 32'h7100, 8);
      fire(4'hD);
      wait_done(0, 400);
      wait_done(3, 400);
      wait_cycles(20);
      check_val("bp_ch2_beats0", vcnt[2], 0);
      check_val("bp_nburst0", iss_addr.size(), 2);
      @(negedge iClk) iCh_afull[2] = 1'b0;
      wait_beat(2, 200);
      iCh_afull[2] = 1'b1;
      wait_cycles(40);
      check_val("bp_inflight_beats", vcnt[2], 7);
      check_val("bp_nburst1", iss_addr.size(), 3);
      if (iss_addr.size() >= 3) begin
         check_val("bp_a2", iss_addr[2], 32'h6004); check_val("bp_b2", iss_bc[2], 7);
      end
      check_val("bp_not_done", dcnt[2], 0);
      @(negedge iClk) iCh_afull[2] = 1'b0;
      wait_done(2, 600);
      check_val("bp_nburst2", iss_addr.size(), 6);
      if (iss_addr.size() == 6) begin
         check_val("bp_a3", iss_addr[3], 32'h6020); check_val("bp_b3", iss_bc[3], 8);
         check_val("bp_a4", iss_addr[4], 32'h6040); check_val("bp_b4", iss_bc[4], 8);
         check_val("bp_a5", iss_addr[5], 32'h6060); check_val("bp_b5", iss_bc[5], 1);
      end
      check_val("bp_beats", vcnt[2], 24);

      // Zero length, then spurious beats while idle.
      clear_logs();
      set_cmd(1, 32'h0ABC, 0);
      fire(4'h2);
      wait_cycles(6);
      check_val("z_done_lat", done_cyc[1] - acc_cyc, 1);
      check_val("z_ndone", dcnt[1], 1);
      check_val("z_noread", rd_seen, 0);
      check_val("z_ready", oCmd_ready, 4'hF);
      spur = 1;
      wait_cycles(4);
      spur = 0;
      check_val("z_spur", vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3], 0);

      // Reset in M_DATA; stale beats after release are ignored.
      clear_logs();
      set_cmd(0, 32'h8000, 16);
      fire(4'h1);
      wait_beat(0, 200);
      @(negedge iClk) iRstn = 1'b0;
      #1 check_reset_outputs("rst1");
      wait_cycles(2);
      @(negedge iClk) iRstn = 1'b1;
      clear_logs();
      set_cmd(0, 32'h9000, 4);
      fire(4'h1);
      wait_done(0, 400);
      check_val("rr_nburst", iss_addr.size(), 1);
      if (iss_addr.size() == 1) begin
         check_val("rr_a0", iss_addr[0], 32'h9000); check_val("rr_b0", iss_bc[0], 4);
      end
      check_val("rr_beats", vcnt[0], 4);

`ifdef RRM_URGENT_EN
      // Urgent ch3 arrives while ch0..2 are busy: it wins the next grant.
      clear_logs();
      set_cmd(0, 32'hA000, 24); set_cmd(1, 32'hB000, 24); set_cmd(2, 32'hC000, 24);
      fire(4'h7);
      begin
         int k = 0;
         while (gq.size() < 1 && k < 200) begin @(negedge iClk); #2; k++; end
      end
      check_val("urg_started", gq.size(), 1);
      iUrgent[3] = 1'b1;
      set_cmd(3, 32'hD000, 8);
      fire(4'h8);
      wait_done(3, 400);
      iUrgent[3] = 1'b0;
      if (gq.size() >= 2) check_val("urg_next_grant", gq[1], 3);
      else                check_val("urg_ngrants", gq.size(), 2);
      for (int c = 0; c < 3; c++) wait_done(c, 800);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
